// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions.
// ALU opcodes, shifter types, flag indices and the result bundle.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  status;
    } alu_out_t;

    function automatic logic [31:0] ror32(
        input logic [31:0] v,
        input logic [4:0]  amt
    );
        logic [63:0] d;
        d = {v, v} >> amt;
        return d[31:0];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX operand bundle into the execute stage and its EX/MEM results.
// master is the decode side, slave is the execute stage.
interface exe_stage_if;
    import arm_pkg::*;

    logic        wb_enable_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        branch_enable_in;
    logic        S_in;
    logic [3:0]  exec_cmd;
    logic [31:0] PC_in;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        immidiate;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_immidiate_24;
    logic [3:0]  Dest_in;
    logic [3:0]  Status_in;

    logic        wb_enable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm_out;
    logic [3:0]  Dest;
    logic [3:0]  Status_reg;
    logic        branch_taken;
    logic [31:0] branch_address;

    modport master (
        output wb_enable_in, mem_read_in, mem_write_in,
        output branch_enable_in, S_in, exec_cmd, PC_in,
        output Val_Rn, Val_Rm, immidiate, Shift_operand,
        output Signed_immidiate_24, Dest_in, Status_in,
        input  wb_enable, mem_read, mem_write, ALU_result,
        input  Val_Rm_out, Dest, Status_reg,
        input  branch_taken, branch_address
    );

    modport slave (
        input  wb_enable_in, mem_read_in, mem_write_in,
        input  branch_enable_in, S_in, exec_cmd, PC_in,
        input  Val_Rn, Val_Rm, immidiate, Shift_operand,
        input  Signed_immidiate_24, Dest_in, Status_in,
        output wb_enable, mem_read, mem_write, ALU_result,
        output Val_Rm_out, Dest, Status_reg,
        output branch_taken, branch_address
    );

endinterface

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated immediate or shifted Rm.
// Purely combinational; ROR #0 passes Rm unchanged (no RRX).
module val2_generator
    import arm_pkg::*;
(
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        mem_access,
    output logic [31:0] val2
);

    logic [4:0] sh_amt;
    logic [3:0] rot;
    logic [31:0] shifted;

    assign sh_amt = shift_operand[11:7];
    assign rot    = shift_operand[11:8];

    always_comb begin
        shifted = val_rm;
        unique case (shift_operand[6:5])
            SH_LSL: shifted = val_rm << sh_amt;
            SH_LSR: shifted = val_rm >> sh_amt;
            SH_ASR: shifted = $signed(val_rm) >>> sh_amt;
            SH_ROR: shifted = ror32(val_rm, sh_amt);
        endcase
    end

    always_comb begin
        val2 = '0;
        unique case (1'b1)
            mem_access:
                val2 = {20'b0, shift_operand};
            !mem_access && imm:
                val2 = ror32({24'b0, shift_operand[7:0]},
                             {rot, 1'b0});
            !mem_access && !imm:
                val2 = shifted;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: ALU, status register and EX/MEM pipeline register.
// Branch target is resolved combinationally alongside.
module exe_stage
    import arm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    exe_stage_if.slave bus
);

    logic [31:0] val2;
    logic [31:0] rn;
    logic        c_in;
    logic [32:0] sum;
    logic [31:0] res;
    logic        c_out;
    logic        v_out;
    logic        known;
    alu_out_t    alu;

    logic        wb_q;
    logic        mr_q;
    logic        mw_q;
    logic [31:0] alu_q;
    logic [31:0] rm_q;
    logic [3:0]  dest_q;
    logic [3:0]  status_q;

    val2_generator u_val2 (
        .val_rm        (bus.Val_Rm),
        .shift_operand (bus.Shift_operand),
        .imm           (bus.immidiate),
        .mem_access    (bus.mem_read_in | bus.mem_write_in),
        .val2          (val2)
    );

    assign rn   = bus.Val_Rn;
    assign c_in = bus.Status_in[FLAG_C];

    always_comb begin
        sum   = '0;
        res   = '0;
        c_out = bus.Status_in[FLAG_C];
        v_out = bus.Status_in[FLAG_V];
        known = 1'b1;
        unique case (bus.exec_cmd)
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum = {1'b0, rn} + {1'b0, val2};
                if (bus.exec_cmd == EXE_ADC)
                    sum = sum + {32'b0, c_in};
                res   = sum[31:0];
                c_out = sum[32];
                v_out = (rn[31] == val2[31]) &&
                        (res[31] != rn[31]);
            end
            EXE_SUB, EXE_SBC: begin
                // Borrow lands in bit 32; ARM carry is its inverse
                sum = {1'b0, rn} - {1'b0, val2};
                if (bus.exec_cmd == EXE_SBC)
                    sum = sum - {32'b0, ~c_in};
                res   = sum[31:0];
                c_out = ~sum[32];
                v_out = (rn[31] != val2[31]) &&
                        (res[31] != rn[31]);
            end
            EXE_AND: res = rn & val2;
            EXE_ORR: res = rn | val2;
            EXE_EOR: res = rn ^ val2;
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        alu.result = res;
        alu.status = bus.Status_in;
        if (known) begin
            alu.status[FLAG_N] = res[31];
            alu.status[FLAG_Z] = (res == 32'b0);
            alu.status[FLAG_C] = c_out;
            alu.status[FLAG_V] = v_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            alu_q    <= '0;
            rm_q     <= '0;
            dest_q   <= '0;
            status_q <= '0;
        end else if (!freeze) begin
            wb_q   <= bus.wb_enable_in;
            mr_q   <= bus.mem_read_in;
            mw_q   <= bus.mem_write_in;
            alu_q  <= alu.result;
            rm_q   <= bus.Val_Rm;
            dest_q <= bus.Dest_in;
            if (bus.S_in)
                status_q <= alu.status;
        end
    end

    assign bus.wb_enable  = wb_q;
    assign bus.mem_read   = mr_q;
    assign bus.mem_write  = mw_q;
    assign bus.ALU_result = alu_q;
    assign bus.Val_Rm_out = rm_q;
    assign bus.Dest       = dest_q;
    assign bus.Status_reg = status_q;

    assign bus.branch_taken   = bus.branch_enable_in;
    assign bus.branch_address = bus.PC_in +
        {{6{bus.Signed_immidiate_24[23]}},
         bus.Signed_immidiate_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage.
// Directed scenarios followed by random vectors against a reference model.
module tb_exe_stage;
    import arm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic freeze;

    exe_stage_if bus ();

    exe_stage dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  st;
    } exp_t;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  st;
    } mres_t;

    exp_t        sb[$];
    exp_t        m;
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] pc_v;
    logic [23:0] off_v;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        check("wb_enable", 32'(bus.wb_enable), 32'(e.wb));
        check("mem_read", 32'(bus.mem_read), 32'(e.mr));
        check("mem_write", 32'(bus.mem_write), 32'(e.mw));
        check("ALU_result", bus.ALU_result, e.alu);
        check("Val_Rm_out", bus.Val_Rm_out, e.rm);
        check("Dest", 32'(bus.Dest), 32'(e.dest));
        check("Status_reg", 32'(bus.Status_reg), 32'(e.st));
    endtask

    function automatic logic [31:0] m_val2(
        input logic [31:0] rm, input logic [11:0] so,
        input logic mem, input logic imm);
        logic [63:0] d;
        logic [4:0]  sh;
        longint      s;
        if (mem) return {20'b0, so};
        if (imm) begin
            d = {24'b0, so[7:0], 24'b0, so[7:0]};
            d = d >> (32'(so[11:8]) * 2);
            return d[31:0];
        end
        sh = so[11:7];
        case (so[6:5])
            2'b00: return rm << sh;
            2'b01: return rm >> sh;
            2'b10: begin
                s = $signed(rm);
                s = s >>> sh;
                return s[31:0];
            end
            default: begin
                d = {rm, rm} >> sh;
                return d[31:0];
            end
        endcase
    endfunction

    function automatic logic ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic mres_t m_alu(
        input logic [3:0] cmd, input logic [31:0] rn,
        input logic [31:0] v2, input logic [3:0] st);
        mres_t  o;
        longint a;
        longint b;
        longint ua;
        longint ub;
        longint k;
        logic   c;
        logic   v;
        a  = $signed(rn);
        b  = $signed(v2);
        ua = {32'b0, rn};
        ub = {32'b0, v2};
        c  = st[1];
        v  = st[0];
        o.r = 32'b0;
        case (cmd)
            4'b0001: o.r = v2;
            4'b1001: o.r = ~v2;
            4'b0110: o.r = rn & v2;
            4'b0111: o.r = rn | v2;
            4'b1000: o.r = rn ^ v2;
            4'b0010, 4'b0011: begin
                k = (cmd == 4'b0011 && st[1]) ? 1 : 0;
                o.r = 32'(ua + ub + k);
                c = (ua + ub + k) > 64'hFFFF_FFFF;
                v = ovf(a + b + k);
            end
            4'b0100, 4'b0101: begin
                k = (cmd == 4'b0101 && !st[1]) ? 1 : 0;
                o.r = 32'(ua - ub - k);
                c = ua >= (ub + k);
                v = ovf(a - b - k);
            end
            default: begin
                o.st = st;
                return o;
            end
        endcase
        o.st = {o.r[31], o.r == 32'b0, c, v};
        return o;
    endfunction

    task automatic set_in(
        input logic [3:0] cmd, input logic s,
        input logic wb, input logic mr, input logic mw,
        input logic br, input logic imm,
        input logic [31:0] rn, input logic [31:0] rm,
        input logic [11:0] so, input logic [3:0] dest);
        bus.exec_cmd            = cmd;
        bus.S_in                = s;
        bus.wb_enable_in        = wb;
        bus.mem_read_in         = mr;
        bus.mem_write_in        = mw;
        bus.branch_enable_in    = br;
        bus.immidiate           = imm;
        bus.Val_Rn              = rn;
        bus.Val_Rm              = rm;
        bus.Shift_operand       = so;
        bus.Dest_in             = dest;
        bus.PC_in               = pc_v;
        bus.Signed_immidiate_24 = off_v;
        bus.Status_in           = m.st;
    endtask

    task automatic drive(
        input logic [3:0] cmd, input logic s,
        input logic wb, input logic mr, input logic mw,
        input logic br, input logic imm,
        input logic [31:0] rn, input logic [31:0] rm,
        input logic [11:0] so, input logic [3:0] dest,
        input logic frz);
        logic [31:0] v2;
        mres_t       a;
        int          o;
        exp_t        e;
        @(negedge clk);
        set_in(cmd, s, wb, mr, mw, br, imm, rn, rm, so, dest);
        freeze = frz;
        v2 = m_val2(rm, so, mr | mw, imm);
        a  = m_alu(cmd, rn, v2, m.st);
        if (!frz) begin
            m.wb   = wb;
            m.mr   = mr;
            m.mw   = mw;
            m.alu  = a.r;
            m.rm   = rm;
            m.dest = dest;
            if (s) m.st = a.st;
        end
        sb.push_back(m);
        #1;
        o = $signed(off_v);
        check("branch_taken", 32'(bus.branch_taken), 32'(br));
        check("branch_address", bus.branch_address,
              pc_v + 32'(o * 4));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out(e);
    endtask

    initial begin
        rst    = 1'b0;
        freeze = 1'b0;
        m      = '0;
        pc_v   = 32'h0;
        off_v  = 24'h0;
        set_in(4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 12'h0, 4'h0);
        #2;
        check_out('0);
        @(posedge clk);
        #1;
        check_out('0);
        @(negedge clk);
        rst = 1'b1;

        drive(EXE_ADD, 1, 1, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'h0,
              12'h001, 4'd1, 0);
        check("add_ovf_res", bus.ALU_result, 32'h8000_0000);
        check("add_ovf_nzcv", 32'(bus.Status_reg), 32'b1001);

        drive(EXE_SUB, 1, 1, 0, 0, 0, 0, 32'd5, 32'd5,
              12'h000, 4'd2, 0);
        check("sub_zero_nzcv", 32'(bus.Status_reg), 32'b0110);

        drive(EXE_MOV, 0, 1, 0, 0, 0, 1, 32'h0, 32'h0,
              12'h4FF, 4'd3, 0);
        check("mov_imm_res", bus.ALU_result, 32'hFF00_0000);
        check("mov_keep_nzcv", 32'(bus.Status_reg), 32'b0110);

        pc_v  = 32'h100;
        off_v = 24'hFFFFFE;
        drive(EXE_MOV, 0, 0, 0, 0, 1, 0, 32'h0, 32'h1234,
              12'h000, 4'd0, 0);
        check("branch_wrap", bus.branch_address, 32'h0000_00F8);

        pc_v  = 32'hFFFF_FFFC;
        off_v = 24'h000001;
        drive(EXE_ADC, 1, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h1,
              12'h000, 4'd4, 0);

        for (int i = 0; i < 3; i++)
            drive(EXE_ADD, 1, 1, 0, 0, 0, 0, 32'h1, 32'h2,
                  12'h000, 4'd5, 1);
        drive(EXE_ADD, 1, 1, 0, 0, 0, 0, 32'h1, 32'h2,
              12'h000, 4'd5, 0);
        check("freeze_release", bus.ALU_result, 32'h3);

        drive(EXE_ORR, 0, 1, 0, 0, 0, 0, 32'h0, 32'h8000_0001,
              12'b00001_11_00000, 4'd6, 0);
        drive(EXE_SBC, 1, 1, 0, 0, 0, 0, 32'h0, 32'h8000_0000,
              12'b00100_10_00000, 4'd7, 0);

        drive(EXE_ADD, 0, 1, 1, 0, 0, 1, 32'h1000, 32'hAB,
              12'h0FC, 4'd8, 0);
        check("ldr_addr", bus.ALU_result, 32'h10FC);

        @(negedge clk);
        set_in(EXE_ADD, 1, 1, 1, 1, 0, 0, 32'h55, 32'h66,
               12'h000, 4'd9);
        #2;
        rst = 1'b0;
        #1;
        m = '0;
        check_out('0);
        @(posedge clk);
        #1;
        check_out('0);
        @(negedge clk);
        rst = 1'b1;
        drive(EXE_EOR, 1, 0, 0, 1, 0, 0, 32'hF0F0_F0F0,
              32'h0FF0_0FF0, 12'h000, 4'd10, 0);

        for (int i = 0; i < 40; i++) begin
            pc_v  = $urandom;
            off_v = 24'($urandom);
            drive(4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom,
                  (i % 7 == 0) ? 32'h8000_0000 : $urandom,
                  12'($urandom),
                  4'($urandom),
                  1'($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
